seq_detector: RTL and testbench

//   Serial bit-pattern detector. Samples one bit of din per rising clk edge, MSB of PATTERN first.

---
 rtl/seq_detector_pkg.sv | 14 +
 rtl/seq_detector_if.sv | 18 +
 rtl/seq_detector_core.sv | 47 ++++
 rtl/seq_detector.sv | 57 +++++
 tb/tb_seq_detector.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_detector_pkg.sv
// Shared definitions for the serial sequence detector: default pattern
// geometry, the optional match-counter width and a fill-counter sizing helper.
package seq_detect_pkg;

  localparam int DEF_PATTERN_W = 5;
  localparam logic [DEF_PATTERN_W-1:0] DEF_PATTERN = 5'b10010;
  localparam int CNT_W = 16;

  // Bits needed for a counter that must be able to hold the value w itself.
  function automatic int fill_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Serial-in / flag-out bundle between the upstream receiver and the detector.
// With SEQ_DETECT_CNT_EN defined the bundle also carries the running match count.
interface seq_detector_if;
  import seq_detect_pkg::*;

  logic din;
  logic flag;
`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] match_cnt;

  modport master (output din, input flag, input match_cnt);
  modport slave  (input din, output flag, output match_cnt);
`else
  modport master (output din, input flag);
  modport slave  (input din, output flag);
`endif

endinterface

// File: rtl/seq_detector_core.sv
// Matching core: keeps the last PATTERN_W-1 received bits plus a saturating
// count of bits seen since reset (or since the last restart when matches may
// not overlap), and raises a combinational match when the newest bit
// completes the pattern over a fully primed history.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN,
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic match
);

  localparam int FW = fill_cnt_w(PATTERN_W);
  localparam logic [FW-1:0] FILL_FULL   = FW'(PATTERN_W);
  localparam logic [FW-1:0] FILL_PRIMED = FW'(PATTERN_W - 1);

  logic [PATTERN_W-2:0] hist;
  logic [FW-1:0]        fill;
  logic [PATTERN_W-1:0] window;

  // The candidate window is the stored history with the bit arriving this edge
  // appended; the fill guard keeps the zeroed reset history from matching.
  assign window = {hist, din};
  assign match  = (fill >= FILL_PRIMED) && (window == PATTERN);

  // Shift history every edge; count fill up to saturation, restarting it on a
  // match when matches are not allowed to share bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= window[PATTERN_W-2:0];
      if (!OVERLAP && match) begin
        fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector top. Wraps the matching core, registers the
// one-cycle match flag and, when SEQ_DETECT_CNT_EN is defined, keeps a
// wrapping count of cycles on which the flag was high.
module seq_detector
  import seq_detect_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN,
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  seq_detector_if.slave  bus
);

  logic match;
  logic flag_q;

  seq_match_core #(
    .PATTERN_W (PATTERN_W),
    .PATTERN   (PATTERN),
    .OVERLAP   (OVERLAP)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.din),
    .match (match)
  );

  // Register the match so the flag is a clean pulse one cycle after the
  // edge that sampled the final pattern bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= match;
    end
  end

  assign bus.flag = flag_q;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] match_cnt_q;

  // Count every cycle the flag is high; natural wrap at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt_q <= '0;
    end else if (flag_q) begin
      match_cnt_q <= match_cnt_q + 1'b1;
    end
  end

  assign bus.match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: several differently configured detectors share one
// serial stream; a bit-stream model predicts every flag (and match count when
// SEQ_DETECT_CNT_EN is defined), checked each cycle, plus directed scenarios
// with hand-derived expectations.
module tb_seq_detector;
  import seq_detect_pkg::*;

  localparam int NDUT = 6;
  localparam int          PW   [NDUT] = '{5, 5, 5, 5, 3, 2};
  localparam logic [31:0] PATS [NDUT] = '{32'b10010, 32'b10010, 32'b0, 32'b0, 32'b101, 32'b11};
  localparam bit          OVL  [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;

  always #5 clk = ~clk;

  logic flag_v [NDUT];
`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_v [NDUT];
`endif

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    seq_detector_if bus ();
    assign bus.din   = din;
    assign flag_v[g] = bus.flag;
`ifdef SEQ_DETECT_CNT_EN
    assign cnt_v[g]  = bus.match_cnt;
`endif
    seq_detector #(
      .PATTERN_W (PW[g]),
      .PATTERN   (PATS[g][PW[g]-1:0]),
      .OVERLAP   (OVL[g])
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Model state: every bit accepted since time zero, and per detector the
  // stream index at which its history was last restarted.
  bit          stream [$];
  int          start_idx [NDUT];
  logic        exp_flag  [NDUT];
  logic [15:0] exp_cnt   [NDUT];
  int          pulse_cnt [NDUT];
  int          hits0 [$];
  int          hits1 [$];
  int          hits3 [$];
  int          scen_pos;
  int          cur_bit;
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] stream1 = 32'b0110_1101_1011_0100_1011_0010_0101_0101;

  // A match on the newest bit: enough bits since restart, and the newest
  // PW bits read oldest-first equal the pattern read MSB-first.
  function automatic bit model_match(input int k);
    int i;
    int w;
    i = stream.size() - 1;
    w = PW[k];
    if (i - start_idx[k] + 1 < w) return 1'b0;
    for (int j = 0; j < w; j++) begin
      if (stream[i - w + 1 + j] != PATS[k][w - 1 - j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clear_log();
    for (int k = 0; k < NDUT; k++) pulse_cnt[k] = 0;
    hits0.delete();
    hits1.delete();
    hits3.delete();
    scen_pos = 0;
  endtask

  task automatic apply_stimulus(input bit b);
    din     = b;
    cur_bit = scen_pos;
    scen_pos++;
    @(posedge clk);
    stream.push_back(b);
    for (int k = 0; k < NDUT; k++) begin
      exp_cnt[k]  = exp_cnt[k] + {15'd0, exp_flag[k]};
      exp_flag[k] = model_match(k);
      if (exp_flag[k] && !OVL[k]) start_idx[k] = stream.size();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      exp_flag[k]  = 1'b0;
      exp_cnt[k]   = '0;
      start_idx[k] = stream.size();
    end
  endtask

  task automatic hold_release(input int cycles);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Per-cycle comparison of every detector against the model.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      n_vec++;
      if (flag_v[k] !== exp_flag[k]) begin
        n_miss++;
        $display("[TB] FAIL flag[%0d] t=%0t: got %b, expected %b", k, $time, flag_v[k], exp_flag[k]);
      end
      if (flag_v[k] === 1'b1) begin
        pulse_cnt[k]++;
        if (k == 0) hits0.push_back(cur_bit);
        if (k == 1) hits1.push_back(cur_bit);
        if (k == 3) hits3.push_back(cur_bit);
      end
`ifdef SEQ_DETECT_CNT_EN
      n_vec++;
      if (cnt_v[k] !== exp_cnt[k]) begin
        n_miss++;
        $display("[TB] FAIL match_cnt[%0d] t=%0t: got %0d, expected %0d", k, $time, cnt_v[k], exp_cnt[k]);
      end
`endif
    end
  end

  initial begin
    assert_reset();
    clear_log();
    hold_release(3);

    // Reference stream: overlapping detector fires after bits 17, 23, 26.
    clear_log();
    for (int i = 0; i < 32; i++) apply_stimulus(stream1[31 - i]);
    check_output("s1_ovl_pulses", hits0.size(), 3);
    check_output("s1_ovl_hit0", hits0[0], 17);
    check_output("s1_ovl_hit1", hits0[1], 23);
    check_output("s1_ovl_hit2", hits0[2], 26);
    check_output("s1_novl_pulses", hits1.size(), 2);
    check_output("s1_novl_hit0", hits1[0], 17);
    check_output("s1_novl_hit1", hits1[1], 23);
`ifdef SEQ_DETECT_CNT_EN
    check_output("s1_cnt_ovl", int'(cnt_v[0]), 3);
    check_output("s1_cnt_novl", int'(cnt_v[1]), 2);
`endif
    assert_reset();
    #1;
`ifdef SEQ_DETECT_CNT_EN
    check_output("s1_cnt_after_rst", int'(cnt_v[0]), 0);
`endif
    hold_release(2);

    // Reset in the middle of a pattern discards the partial progress.
    clear_log();
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    assert_reset();
    hold_release(2);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("midrst_no_flag", pulse_cnt[0], 0);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("midrst_one_flag", pulse_cnt[0], 1);
    check_output("midrst_flag_pos", hits0[0], 7);

    // All-zero pattern from reset release.
    assert_reset();
    hold_release(2);
    clear_log();
    repeat (20) apply_stimulus(1'b0);
    check_output("zero_ovl_pulses", pulse_cnt[2], 16);
    check_output("zero_novl_pulses", pulse_cnt[3], 4);
    check_output("zero_novl_first", hits3[0], 4);
    check_output("zero_novl_last", hits3[3], 19);

    // Asynchronous reset clears a high flag before the next edge.
    check_output("async_flag_before", int'(flag_v[2]), 1);
    assert_reset();
    #1;
    check_output("async_flag_cleared", int'(flag_v[2]), 0);
    hold_release(2);

    // Random traffic with occasional resets.
    clear_log();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        assert_reset();
        hold_release(int'($urandom_range(1, 3)));
      end else begin
        apply_stimulus(bit'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
